// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline stage registers and the hazard unit.
package pipe_pkg;

  localparam int unsigned REG_W_DFLT  = 5;
  localparam int unsigned TNEW_W_DFLT = 3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] REG_ZERO  = 32'h0000_0000;

  // Saturating decrement; callers cast the result back to their own field width.
  function automatic logic [31:0] tnew_dec(input logic [31:0] tnew);
    return (tnew == 32'd0) ? 32'd0 : tnew - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stat_cnt.sv
// 32-bit enable counter with synchronous active-high reset; wraps modulo 2^32.
module pipe_stat_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (en) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, valid and a forwarding descriptor.
// Define PIPE_STAGE_STAT_EN to add stall/bubble statistics counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned REG_W     = REG_W_DFLT,
  parameter int unsigned TNEW_W    = TNEW_W_DFLT,
  parameter int unsigned DEC_TNEW  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_instr,
  input  logic [NUM_WORDS*DATA_W-1:0]   in_words,
  input  logic [REG_W-1:0]              in_wreg,
  input  logic [TNEW_W-1:0]             in_tnew,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_instr,
  output logic [NUM_WORDS*DATA_W-1:0]   out_words,
  output logic [REG_W-1:0]              out_wreg,
  output logic [TNEW_W-1:0]             out_tnew,
  output logic                          fwd_en,
`ifdef PIPE_STAGE_STAT_EN
  output logic [31:0]                   stat_stall_cnt,
  output logic [31:0]                   stat_bubble_cnt,
`endif
  output logic [REG_W-1:0]              fwd_reg
);

  logic                        valid_q;
  logic [DATA_W-1:0]           instr_q;
  logic [NUM_WORDS*DATA_W-1:0] words_q;
  logic [REG_W-1:0]            wreg_q;
  logic [TNEW_W-1:0]           tnew_q;

  logic [TNEW_W-1:0] tnew_d;
  logic [REG_W-1:0]  wreg_d;

  always_comb begin
    tnew_d = in_tnew;
    if (DEC_TNEW != 0) begin
      tnew_d = TNEW_W'(tnew_dec(32'(in_tnew)));
    end
    // A dead slot must never advertise a forwardable result downstream.
    wreg_d = in_wreg;
    if (!in_valid) begin
      tnew_d = '0;
      wreg_d = REG_W'(REG_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      instr_q <= DATA_W'(NOP_INSTR);
      words_q <= '0;
      wreg_q  <= REG_W'(REG_ZERO);
      tnew_q  <= '0;
    end else if (!stall) begin
      valid_q <= in_valid;
      instr_q <= in_instr;
      words_q <= in_words;
      wreg_q  <= wreg_d;
      tnew_q  <= tnew_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_words = words_q;
  assign out_wreg  = wreg_q;
  assign out_tnew  = tnew_q;

  assign fwd_en  = valid_q && (wreg_q != '0) && (tnew_q == '0);
  assign fwd_reg = fwd_en ? wreg_q : REG_W'(REG_ZERO);

`ifdef PIPE_STAGE_STAT_EN
  logic stall_edge;
  logic bubble_edge;

  assign stall_edge  = stall && !flush && !reset;
  assign bubble_edge = !reset && (flush || (!stall && !in_valid));

  pipe_stat_cnt u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_edge),
    .count (stat_stall_cnt)
  );

  pipe_stat_cnt u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bubble_edge),
    .count (stat_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default parameters).
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         flush;
  logic         in_valid;
  logic [31:0]  in_instr;
  logic [127:0] in_words;
  logic [4:0]   in_wreg;
  logic [2:0]   in_tnew;
  logic         out_valid;
  logic [31:0]  out_instr;
  logic [127:0] out_words;
  logic [4:0]   out_wreg;
  logic [2:0]   out_tnew;
  logic         fwd_en;
  logic [4:0]   fwd_reg;
`ifdef PIPE_STAGE_STAT_EN
  logic [31:0]  stat_stall_cnt;
  logic [31:0]  stat_bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_words  (in_words),
    .in_wreg   (in_wreg),
    .in_tnew   (in_tnew),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_words (out_words),
    .out_wreg  (out_wreg),
    .out_tnew  (out_tnew),
    .fwd_en    (fwd_en),
`ifdef PIPE_STAGE_STAT_EN
    .stat_stall_cnt  (stat_stall_cnt),
    .stat_bubble_cnt (stat_bubble_cnt),
`endif
    .fwd_reg   (fwd_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    stall    = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hFFFF_FFFF;
    in_words = '1;
    in_wreg  = 5'h1F;
    in_tnew  = 3'h7;
    step();
    step();
    check("rst_valid", 128'(out_valid), 128'h0);
    check("rst_instr", 128'(out_instr), 128'h0);
    check("rst_words", out_words, 128'h0);
    check("rst_wreg", 128'(out_wreg), 128'h0);
    check("rst_tnew", 128'(out_tnew), 128'h0);
    check("rst_fwd_en", 128'(fwd_en), 128'h0);
    check("rst_fwd_reg", 128'(fwd_reg), 128'h0);

    // First load after reset release
    reset    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h8C08_0004;
    in_words = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    in_wreg  = 5'd8;
    in_tnew  = 3'd2;
    step();
    check("ld_valid", 128'(out_valid), 128'h1);
    check("ld_instr", 128'(out_instr), 128'h8C08_0004);
    check("ld_words", out_words, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    check("ld_wreg", 128'(out_wreg), 128'd8);
    check("ld_tnew", 128'(out_tnew), 128'd1);
    check("ld_fwd_en", 128'(fwd_en), 128'h0);
    check("ld_fwd_reg", 128'(fwd_reg), 128'h0);

    // T_new 1 -> 0 makes the stage forwardable
    in_tnew = 3'd1;
    in_wreg = 5'd3;
    step();
    check("t1_tnew", 128'(out_tnew), 128'd0);
    check("t1_fwd_en", 128'(fwd_en), 128'h1);
    check("t1_fwd_reg", 128'(fwd_reg), 128'd3);

    // T_new 0 saturates instead of wrapping to 7
    in_tnew = 3'd0;
    step();
    check("t0_tnew", 128'(out_tnew), 128'd0);
    check("t0_fwd_en", 128'(fwd_en), 128'h1);

    // Stall hold across changing inputs
    in_words = 128'h0000_3000;
    in_wreg  = 5'd4;
    in_tnew  = 3'd2;
    step();
    check("sh_pre_word0", 128'(out_words[31:0]), 128'h3000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_words = {4{32'hA000_0000 + 32'(i)}};
      in_tnew  = 3'd5;
      in_wreg  = 5'd9;
      step();
      check("sh_word0", 128'(out_words[31:0]), 128'h3000);
      check("sh_tnew", 128'(out_tnew), 128'd1);
      check("sh_wreg", 128'(out_wreg), 128'd4);
    end
    stall    = 1'b0;
    in_words = {4{32'h5A5A_5A5A}};
    step();
    check("sh_release", out_words, {4{32'h5A5A_5A5A}});
    check("sh_rel_tnew", 128'(out_tnew), 128'd4);

    // Flush wins over stall
    stall = 1'b1;
    flush = 1'b1;
    step();
    check("fl_valid", 128'(out_valid), 128'h0);
    check("fl_instr", 128'(out_instr), 128'h0);
    check("fl_words", out_words, 128'h0);
    check("fl_wreg", 128'(out_wreg), 128'h0);
    check("fl_fwd_en", 128'(fwd_en), 128'h0);
    stall    = 1'b0;
    flush    = 1'b0;
    in_instr = 32'h1234_5678;
    in_wreg  = 5'd5;
    in_tnew  = 3'd1;
    step();
    check("fl_rest_valid", 128'(out_valid), 128'h1);
    check("fl_rest_instr", 128'(out_instr), 128'h1234_5678);
    check("fl_rest_fwd_reg", 128'(fwd_reg), 128'd5);

    // Dead slot never forwards
    in_valid = 1'b0;
    in_instr = 32'hDEAD_BEEF;
    in_wreg  = 5'd31;
    in_tnew  = 3'd0;
    step();
    check("dead_valid", 128'(out_valid), 128'h0);
    check("dead_instr", 128'(out_instr), 128'hDEAD_BEEF);
    check("dead_wreg", 128'(out_wreg), 128'h0);
    check("dead_fwd_en", 128'(fwd_en), 128'h0);
    check("dead_fwd_reg", 128'(fwd_reg), 128'h0);

    // Reset mid-operation
    in_valid = 1'b1;
    in_wreg  = 5'd7;
    in_tnew  = 3'd1;
    step();
    check("mid_pre_fwd", 128'(fwd_reg), 128'd7);
    reset = 1'b1;
    step();
    check("mid_valid", 128'(out_valid), 128'h0);
    check("mid_instr", 128'(out_instr), 128'h0);
    check("mid_words", out_words, 128'h0);
    check("mid_fwd_en", 128'(fwd_en), 128'h0);

`ifdef PIPE_STAGE_STAT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    stall = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) step();
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    check("stat_stall", 128'(stat_stall_cnt), 128'd5);
    check("stat_bubble", 128'(stat_bubble_cnt), 128'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("stat_stall_rst", 128'(stat_stall_cnt), 128'd0);
    check("stat_bubble_rst", 128'(stat_bubble_cnt), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
